// File: rtl/musb_pipeline_ctrl_if.sv
// rtl/musb_pipeline_ctrl_if.sv - stall/flush request and control bundle for the MUSB pipeline sequencer
//
// Purpose: groups the per-stage stall requests, the exception handshake and the
//          stall/flush controls that musb_pipeline_ctrl drives to the pipeline registers.
// Ports (signals):
//   requests : if_req_stall, id_hazard, ex_busy, mem_req_stall, exc_request
//   controls : if/id/ex/mem_stall, if/id/ex/mem_flush, exc_pc_sel, exc_ack
//   observers: stall_timeout, perf_stall_cnt[31:0]
// Modports: master drives the requests (pipeline side), slave is the sequencer.
interface musb_pipeline_ctrl_if;
  logic        if_req_stall;
  logic        id_hazard;
  logic        ex_busy;
  logic        mem_req_stall;
  logic        exc_request;
  logic        if_stall;
  logic        id_stall;
  logic        ex_stall;
  logic        mem_stall;
  logic        if_flush;
  logic        id_flush;
  logic        ex_flush;
  logic        mem_flush;
  logic        exc_pc_sel;
  logic        exc_ack;
  logic        stall_timeout;
  logic [31:0] perf_stall_cnt;

  modport master (
    output if_req_stall, id_hazard, ex_busy, mem_req_stall, exc_request,
    input  if_stall, id_stall, ex_stall, mem_stall,
    input  if_flush, id_flush, ex_flush, mem_flush,
    input  exc_pc_sel, exc_ack, stall_timeout, perf_stall_cnt
  );

  modport slave (
    input  if_req_stall, id_hazard, ex_busy, mem_req_stall, exc_request,
    output if_stall, id_stall, ex_stall, mem_stall,
    output if_flush, id_flush, ex_flush, mem_flush,
    output exc_pc_sel, exc_ack, stall_timeout, perf_stall_cnt
  );
endinterface

// File: rtl/musb_pipeline_ctrl.sv
// rtl/musb_pipeline_ctrl.sv - stall/flush sequencer with exception entry, watchdog and stall counter
//
// Purpose: turns per-stage not-ready and hazard requests into stall controls for the
//          IF/ID, ID/EX, EX/MEM and MEM/WB registers, runs the exception entry
//          sequence (drain MEM, redirect PC, flush all stages), watches for stuck
//          stalls and counts stalled cycles.
// Ports:
//   clk  - main clock
//   rst  - synchronous active-high reset
//   bus  - musb_pipeline_ctrl_if.slave (requests in, stall/flush/exception controls out)
// Parameters:
//   STALL_TIMEOUT - consecutive id_stall cycles per stall_timeout pulse
//   CNT_W         - watchdog counter width
module musb_pipeline_ctrl #(
  parameter int STALL_TIMEOUT = 255,
  parameter int CNT_W         = 8
) (
  input logic                clk,
  input logic                rst,
  musb_pipeline_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, DRAIN, REDIRECT} state_t;

  state_t           state;
  logic             redirect_q;   // registered twin of state==REDIRECT, drives flush/ack
  logic [CNT_W-1:0] wd_cnt;
  logic [31:0]      perf_cnt;

  logic mem_stall_c;
  logic ex_stall_c;
  logic id_stall_c;
  logic if_stall_c;
  logic wd_hit;

  // Each stall also holds every earlier stage; the redirect cycle releases all of
  // them so the exception vector fetch enters a freshly flushed pipeline.
  always_comb begin
    mem_stall_c = 1'b0;
    ex_stall_c  = 1'b0;
    id_stall_c  = 1'b0;
    if_stall_c  = 1'b0;
    if (!redirect_q) begin
      mem_stall_c = bus.mem_req_stall | (state == DRAIN);
      ex_stall_c  = mem_stall_c | bus.ex_busy;
      id_stall_c  = ex_stall_c | bus.id_hazard;
      if_stall_c  = id_stall_c | bus.if_req_stall;
    end
  end

  // The counter holds the number of earlier stalled cycles in this run, so it
  // reaches STALL_TIMEOUT-1 on the STALL_TIMEOUT-th stalled cycle.
  assign wd_hit = id_stall_c && (wd_cnt == CNT_W'(STALL_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      redirect_q <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      case (state)
        RUN: begin
          if (bus.exc_request) begin
            if (bus.mem_req_stall) begin
              state <= DRAIN;
            end else begin
              state      <= REDIRECT;
              redirect_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!bus.mem_req_stall) begin
            state      <= REDIRECT;
            redirect_q <= 1'b1;
          end
        end
        REDIRECT: state <= RUN;   // exc_request is not looked at here
        default:  state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt   <= '0;
      perf_cnt <= '0;
    end else begin
      if (!id_stall_c || wd_hit) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (id_stall_c) begin
        perf_cnt <= perf_cnt + 32'd1;
      end
    end
  end

  assign bus.mem_stall      = mem_stall_c;
  assign bus.ex_stall       = ex_stall_c;
  assign bus.id_stall       = id_stall_c;
  assign bus.if_stall       = if_stall_c;
  assign bus.if_flush       = redirect_q;
  assign bus.id_flush       = redirect_q;
  assign bus.ex_flush       = redirect_q;
  assign bus.mem_flush      = redirect_q;
  assign bus.exc_pc_sel     = redirect_q;
  assign bus.exc_ack        = redirect_q;
  assign bus.stall_timeout  = wd_hit;
  assign bus.perf_stall_cnt = perf_cnt;

endmodule

// File: tb/tb_musb_pipeline_ctrl.sv
// tb/tb_musb_pipeline_ctrl.sv - scoreboard bench for musb_pipeline_ctrl against a cycle-level reference model
module tb_musb_pipeline_ctrl;
  localparam int TO = 4;

  logic clk;
  logic rst;

  musb_pipeline_ctrl_if bus ();

  musb_pipeline_ctrl #(.STALL_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] flags;  // if,id,ex,mem stall; if,id,ex,mem flush; pc_sel; ack; timeout
    logic [31:0] perf;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: exception progress described as "waiting for MEM to drain"
  // and "redirecting this cycle", plus plain integer counters.
  bit          known = 0;
  bit          m_waiting;
  bit          m_redirecting;
  int          m_run_len;      // consecutive stalled cycles since last pulse/clear
  logic [31:0] m_perf;

  always @(negedge clk) begin
    exp_t e;
    logic [10:0] act;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall,
             bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush,
             bus.exc_pc_sel, bus.exc_ack, bus.stall_timeout};
      tests++;
      if (act !== e.flags) begin
        fails++;
        $display("FAIL ctrl_flags t=%0t actual=%b required=%b", $time, act, e.flags);
      end
      tests++;
      if (bus.perf_stall_cnt !== e.perf) begin
        fails++;
        $display("FAIL perf_stall_cnt t=%0t actual=%0d required=%0d", $time, bus.perf_stall_cnt, e.perf);
      end
    end
  end

  // One clock cycle: apply inputs, predict this cycle's outputs, advance the model.
  task automatic step(input bit r, input bit ifr, input bit hz, input bit busy,
                      input bit mreq, input bit exc);
    exp_t e;
    bit   s_mem, s_ex, s_id, s_if, tmo;
    rst               = r;
    bus.if_req_stall  = ifr;
    bus.id_hazard     = hz;
    bus.ex_busy       = busy;
    bus.mem_req_stall = mreq;
    bus.exc_request   = exc;
    if (m_redirecting) begin
      s_mem = 0; s_ex = 0; s_id = 0; s_if = 0;
    end else begin
      s_mem = mreq || m_waiting;
      s_ex  = s_mem || busy;
      s_id  = s_ex || hz;
      s_if  = s_id || ifr;
    end
    tmo = s_id && (m_run_len + 1 == TO);
    e.flags = {s_if, s_id, s_ex, s_mem, {6{m_redirecting}}, tmo};
    e.perf  = m_perf;
    if (known) sb_q.push_back(e);
    @(posedge clk);
    if (r) begin
      known = 1; m_waiting = 0; m_redirecting = 0; m_run_len = 0; m_perf = 0;
    end else begin
      if (s_id) m_perf = m_perf + 1;
      m_run_len = (!s_id || tmo) ? 0 : m_run_len + 1;
      if (m_redirecting) begin
        m_redirecting = 0;
      end else if (m_waiting) begin
        if (!mreq) begin m_waiting = 0; m_redirecting = 1; end
      end else if (exc) begin
        if (mreq) m_waiting = 1; else m_redirecting = 1;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.if_req_stall = 0; bus.id_hazard = 0; bus.ex_busy = 0;
    bus.mem_req_stall = 0; bus.exc_request = 0;
    #1;
    // 1: reset, two cycles
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // 2: stall chain, one input at a time
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // 3: exception with MEM ready; request held in the redirect cycle is ignored
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // 4: exception during a 3-cycle mem_req_stall, second request in REDIRECT
    step(0, 0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // 5: watchdog, ex_busy for 10 cycles, after a reset to clear counters
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // reset while draining
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // randomized traffic; exceptions stay high until the model acknowledges them
    begin
      bit exc_hold = 0;
      for (int i = 0; i < 600; i++) begin
        bit r;
        r = ($urandom_range(0, 79) == 0);
        if (!exc_hold) exc_hold = ($urandom_range(0, 11) == 0);
        step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0), exc_hold);
        if (m_redirecting || r) exc_hold = 0;
      end
    end
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
